// File: rtl/seg7_pkg.sv
// Shared definitions for the active-low 7-segment display path (driver and capture).
// Segment order is {a,b,c,d,e,f,g}, bit 6 = a; a 0 lights the segment.
package seg7_pkg;

  localparam logic [6:0] SEG7_GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern to its hex value.
// legal is set only for the 16 hex glyphs; blank is reported separately.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] val
);

  always_comb begin
    legal = 1'b0;
    val   = '0;
    blank = (seg == SEG7_BLANK);
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG7_GLYPHS[i]) begin
        legal = 1'b1;
        val   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers per-digit hex values from a multiplexed active-low 7-segment bus.
// Optional decimal-point capture is enabled by defining SEG7_CAPTURE_DP_EN.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg7,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    err,
  output logic [6:0]              err_pattern
`ifdef SEG7_CAPTURE_DP_EN
  ,
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp
`endif
);

  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_an;
  logic [3:0]            cnt;
  logic                  changed;
  logic                  one_hot;
  logic [IDX_W-1:0]      idx;
  logic                  fire;
  logic                  g_legal;
  logic                  g_blank;
  logic [3:0]            g_val;
  state_t                state;
  state_t                state_n;
`ifdef SEG7_CAPTURE_DP_EN
  logic                  s_dp;
`endif

  always_comb begin
    changed = (seg7 != s_seg) || (an_n != s_an);
`ifdef SEG7_CAPTURE_DP_EN
    changed = changed || (dp_n != s_dp);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg <= '1;
      s_an  <= '1;
      cnt   <= '0;
`ifdef SEG7_CAPTURE_DP_EN
      s_dp  <= 1'b1;
`endif
    end else begin
      s_seg <= seg7;
      s_an  <= an_n;
`ifdef SEG7_CAPTURE_DP_EN
      s_dp  <= dp_n;
`endif
      if (changed)
        cnt <= 4'd1;
      else if (cnt != 4'(STABLE_CYCLES))
        cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    one_hot = ($countones(~s_an) == 1);
    idx     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an[i])
        idx = IDX_W'(i);
    end
  end

  seg7_to_hex u_dec (
    .seg   (s_seg),
    .legal (g_legal),
    .blank (g_blank),
    .val   (g_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // cnt==1 means the sample register took a new value on the last edge.
  always_comb begin
    state_n = state;
    fire    = 1'b0;
    case (state)
      IDLE:
        if (one_hot)
          state_n = TRACK;
      TRACK:
        if (!one_hot)
          state_n = IDLE;
        else if (cnt == 4'(STABLE_CYCLES)) begin
          state_n = HELD;
          fire    = 1'b1;
        end
      HELD:
        if (cnt == 4'd1)
          state_n = one_hot ? TRACK : IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      err         <= 1'b0;
      err_pattern <= '1;
`ifdef SEG7_CAPTURE_DP_EN
      dp          <= '0;
`endif
    end else begin
      upd <= 1'b0;
      err <= 1'b0;
      if (fire) begin
        if (g_legal) begin
          digits[{idx, 2'b00} +: 4] <= g_val;
          digit_valid[idx]          <= 1'b1;
          upd                       <= 1'b1;
          upd_idx                   <= idx;
`ifdef SEG7_CAPTURE_DP_EN
          dp[idx]                   <= ~s_dp;
`endif
        end else if (g_blank) begin
          digit_valid[idx] <= 1'b0;
          upd_idx          <= idx;
`ifdef SEG7_CAPTURE_DP_EN
          dp[idx]          <= ~s_dp;
`endif
        end else begin
          err         <= 1'b1;
          err_pattern <= s_seg;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: edge-accurate episode model feeds a scoreboard
// of expected upd/err pulses; register state is compared after each phase.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg7 = 7'b1111111;
  logic [1:0] an_n = 2'b11;
  logic       dp_n = 1'b1;
  logic [7:0] digits;
  logic [1:0] digit_valid;
  logic       upd;
  logic [0:0] upd_idx;
  logic       err;
  logic [6:0] err_pattern;
`ifdef SEG7_CAPTURE_DP_EN
  logic [1:0] dp;
`endif

  always #5 clk = ~clk;

  seg7_capture #(.NUM_DIGITS(2), .STABLE_CYCLES(4), .IDX_W(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg7        (seg7),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err),
    .err_pattern (err_pattern)
`ifdef SEG7_CAPTURE_DP_EN
    ,
    .dp_n        (dp_n),
    .dp          (dp)
`endif
  );

  typedef struct {
    bit         is_err;
    int         idx;
    logic [3:0] val;
    logic [6:0] pat;
    int         edge_no;
  } exp_t;

  exp_t q[$];

  logic [6:0] glyph [16];
  int         n_total = 0;
  int         n_pass  = 0;
  int         ecount  = 0;
  int         ep_len  = 0;
  bit         ep_done = 0;
  logic [7:0] m_digits = '0;
  logic [1:0] m_valid = '0;
  logic [0:0] m_idx = '0;
  logic [6:0] m_pat = 7'b1111111;
  logic [1:0] m_dp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_edge();
    exp_t e;
    int   hit;
    int   id;
    ecount++;
    if (ep_len < 1000) ep_len++;
    if (ep_len == 4 && !ep_done && (an_n == 2'b10 || an_n == 2'b01)) begin
      ep_done = 1;
      id  = (an_n == 2'b10) ? 0 : 1;
      hit = -1;
      for (int g = 0; g < 16; g++)
        if (seg7 == glyph[g]) hit = g;
      if (hit >= 0) begin
        m_digits[id*4 +: 4] = 4'(hit);
        m_valid[id] = 1'b1;
        m_idx       = 1'(id);
        m_dp[id]    = ~dp_n;
        e = '{is_err: 0, idx: id, val: 4'(hit), pat: 7'h0, edge_no: ecount};
        q.push_back(e);
      end else if (seg7 == 7'b1111111) begin
        m_valid[id] = 1'b0;
        m_idx       = 1'(id);
        m_dp[id]    = ~dp_n;
      end else begin
        m_pat = seg7;
        e = '{is_err: 1, idx: id, val: 4'h0, pat: seg7, edge_no: ecount};
        q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    chk("upd_err_exclusive", 32'(upd & err), 32'd0);
    if (upd || err) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'({upd, err}), 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_latency", 32'(ecount - e.edge_no), 32'd1);
        if (e.is_err) begin
          chk("err_pulse", 32'(err), 32'd1);
          chk("err_pattern", 32'(err_pattern), 32'(e.pat));
        end else begin
          chk("upd_pulse", 32'(upd), 32'd1);
          chk("upd_idx", 32'(upd_idx), 32'(e.idx));
          chk("upd_val", 32'(digits[e.idx*4 +: 4]), 32'(e.val));
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    monitor();
  endtask

  task automatic run(input logic [6:0] s, input logic [1:0] a, input int n, input logic d = 1'b1);
    if (s != seg7 || a != an_n || d != dp_n) begin
      ep_len  = 0;
      ep_done = 0;
    end
    seg7 = s;
    an_n = a;
    dp_n = d;
    repeat (n) cycle();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'(m_digits));
    chk({tag, "_valid"}, 32'(digit_valid), 32'(m_valid));
    chk({tag, "_upd_idx"}, 32'(upd_idx), 32'(m_idx));
    chk({tag, "_err_pattern"}, 32'(err_pattern), 32'(m_pat));
    chk({tag, "_queue_drained"}, 32'(q.size()), 32'd0);
`ifdef SEG7_CAPTURE_DP_EN
    chk({tag, "_dp"}, 32'(dp), 32'(m_dp));
`endif
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'd0);
    chk({tag, "_valid"}, 32'(digit_valid), 32'd0);
    chk({tag, "_upd"}, 32'(upd), 32'd0);
    chk({tag, "_upd_idx"}, 32'(upd_idx), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_pattern"}, 32'(err_pattern), 32'h7f);
`ifdef SEG7_CAPTURE_DP_EN
    chk({tag, "_dp"}, 32'(dp), 32'd0);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    ep_len   = 0;
    ep_done  = 0;
    m_digits = '0;
    m_valid  = '0;
    m_idx    = '0;
    m_pat    = 7'b1111111;
    m_dp     = '0;
  endtask

  initial begin
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reset with a glyph already on the bus, then exact capture latency.
    seg7 = 7'b0000110;
    an_n = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk($sformatf("latency_upd_edge%0d", i), 32'(upd), 32'(i == 5));
    end
    check_state("after_reset");
    chk("first_digit", 32'(digits[3:0]), 32'h3);

    // Multiplex scan, two rounds.
    for (int r = 0; r < 2; r++) begin
      run(7'b1001100, 2'b10, 8);
      run(7'b0111000, 2'b01, 8);
    end
    run(7'b1111111, 2'b11, 3);
    check_state("scan");
    chk("scan_digits_f4", 32'(digits), 32'hF4);
    chk("scan_valid_11", 32'(digit_valid), 32'h3);

    // Glitch: 5 too short, then 8 long enough.
    run(7'b0100100, 2'b10, 3);
    run(7'b0000000, 2'b10, 6);
    run(7'b1111111, 2'b11, 3);
    check_state("glitch");
    chk("glitch_digits_f8", 32'(digits), 32'hF8);

    // Illegal stable pattern on digit 1.
    run(7'b1010101, 2'b01, 6);
    run(7'b1111111, 2'b11, 3);
    check_state("illegal");
    chk("illegal_pattern", 32'(err_pattern), 32'h55);

    // Blank on digit 0, then no-enable and multi-enable periods.
    run(7'b1111111, 2'b10, 6);
    run(7'b1111111, 2'b11, 20);
    run(7'b0000001, 2'b00, 20);
    run(7'b1111111, 2'b11, 3);
    check_state("blank_noenable");
    chk("blank_valid_10", 32'(digit_valid), 32'h2);

    // Enable change alone restarts counting; glyph 7 with decimal point lands on digit 1.
    run(7'b0001111, 2'b10, 2, 1'b0);
    run(7'b0001111, 2'b01, 6, 1'b0);
    run(7'b1111111, 2'b11, 3);
    check_state("an_change");
    chk("an_change_digits", 32'(digits), 32'h78);

    // Asynchronous reset while counting, then a fresh episode.
    run(7'b0100000, 2'b10, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_track_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle();
    check_reset_values("post_release");
    repeat (4) cycle();
    check_state("fresh_after_reset");
    chk("fresh_digit6", 32'(digits), 32'h06);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
